// File: rtl/seg_display_scan_pkg.sv
// Shared constants for the 7-segment scanner: glyphs in active-high {g,f,e,d,c,b,a} form
// and the default digit count.
package seg_pkg;

   localparam int NUM_DIGITS_DEFAULT = 4;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg_display_scan_if.sv
// Bundle between the game/score logic (master) and the display scanner (slave).
interface seg_display_scan_if
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT
);
   logic                    clk_fast;
   logic                    clk_blink;
   logic [4*NUM_DIGITS-1:0] digits_bcd;
   logic [NUM_DIGITS-1:0]   dp_mask;
   logic [NUM_DIGITS-1:0]   blink_mask;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic [6:0]              seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   an;

   modport master (
      output clk_fast, clk_blink, digits_bcd, dp_mask, blink_mask, blank_mask,
      input  seg, dp, an
   );

   modport slave (
      input  clk_fast, clk_blink, digits_bcd, dp_mask, blink_mask, blank_mask,
      output seg, dp, an
   );
endinterface

// File: rtl/seg_display_scan_bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment glyph; codes 10-15 render as a dash.
module bcd_to_seg7
   import seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] glyph
);

   // Glyph lookup
   always_comb begin
      glyph = SEG_DASH;
      case (bcd)
         4'd0:    glyph = SEG_0;
         4'd1:    glyph = SEG_1;
         4'd2:    glyph = SEG_2;
         4'd3:    glyph = SEG_3;
         4'd4:    glyph = SEG_4;
         4'd5:    glyph = SEG_5;
         4'd6:    glyph = SEG_6;
         4'd7:    glyph = SEG_7;
         4'd8:    glyph = SEG_8;
         4'd9:    glyph = SEG_9;
         default: glyph = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed 7-segment driver: steps one digit per clk_fast rise, with a one-cycle
// all-anodes-off guard at each step to avoid ghosting, plus blink and blank masking.
module seg_display_scan
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS     = NUM_DIGITS_DEFAULT,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input logic               master_clk,
   input logic               rst,
   seg_display_scan_if.slave bus
);

   localparam int                    IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_IDLE  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
   localparam logic [6:0]            SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
   localparam logic                  DP_IDLE  = SEG_ACTIVE_LOW;

   logic                  fast_s1, fast_s2, fast_prev;
   logic                  blink_s1, blink_s2;
   logic                  tick;
   logic [IDX_W-1:0]      idx;
   logic                  guard;
   logic                  dark;
   logic [3:0]            digit;
   logic [6:0]            glyph;
   logic [NUM_DIGITS-1:0] an_lit;
   logic [NUM_DIGITS-1:0] an_next;
   logic [6:0]            seg_next;
   logic                  dp_next;
   logic [NUM_DIGITS-1:0] an_q;
   logic [6:0]            seg_q;
   logic                  dp_q;

   // Synchronise the divided clock levels and remember the last fast level
   always_ff @(posedge master_clk or negedge rst) begin
      if (!rst) begin
         fast_s1   <= 1'b0;
         fast_s2   <= 1'b0;
         fast_prev <= 1'b0;
         blink_s1  <= 1'b0;
         blink_s2  <= 1'b0;
      end else begin
         fast_s1   <= bus.clk_fast;
         fast_s2   <= fast_s1;
         fast_prev <= fast_s2;
         blink_s1  <= bus.clk_blink;
         blink_s2  <= blink_s1;
      end
   end

   assign tick = fast_s2 & ~fast_prev;

   bcd_to_seg7 u_dec (
      .bcd   (digit),
      .glyph (glyph)
   );

   // Next output pattern for the currently selected digit
   always_comb begin
      digit  = bus.digits_bcd[4*int'(idx) +: 4];
      an_lit = NUM_DIGITS'(1'b1) << idx;
      dark   = bus.blank_mask[idx] | (bus.blink_mask[idx] & blink_s2);
      if (dark) begin
         an_next  = AN_IDLE;
         seg_next = SEG_IDLE;
         dp_next  = DP_IDLE;
      end else begin
         an_next  = AN_ACTIVE_LOW  ? ~an_lit            : an_lit;
         seg_next = SEG_ACTIVE_LOW ? ~glyph             : glyph;
         dp_next  = SEG_ACTIVE_LOW ? ~bus.dp_mask[idx]  : bus.dp_mask[idx];
      end
   end

   // Scan index, ghost guard and registered pins; seg/dp hold through the guard cycle
   always_ff @(posedge master_clk or negedge rst) begin
      if (!rst) begin
         idx   <= {IDX_W{1'b0}};
         guard <= 1'b0;
         an_q  <= AN_IDLE;
         seg_q <= SEG_IDLE;
         dp_q  <= DP_IDLE;
      end else if (tick) begin
         idx   <= (idx == IDX_LAST) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
         guard <= 1'b1;
         an_q  <= AN_IDLE;
      end else if (guard) begin
         guard <= 1'b0;
         an_q  <= an_next;
         seg_q <= seg_next;
         dp_q  <= dp_next;
      end else begin
         an_q  <= an_next;
         seg_q <= seg_next;
         dp_q  <= dp_next;
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed + randomised bench for seg_display_scan against a sample-history reference model.
module tb_seg_display_scan;

   logic master_clk = 1'b0;
   logic rst;

   seg_display_scan_if #(.NUM_DIGITS(4)) bus ();

   seg_display_scan #(
      .NUM_DIGITS     (4),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) dut (
      .master_clk (master_clk),
      .rst        (rst),
      .bus        (bus.slave)
   );

   always #5 master_clk = ~master_clk;

   int          vectors     = 0;
   int          miscompares = 0;
   int          fast_cnt    = 0;
   // Model: recent clk_fast / clk_blink samples (newest in bit 0), digit position, pins
   logic [2:0]  fh;
   logic [1:0]  bh;
   int          pos;
   logic [11:0] exp_o;
   bit          found;

   function automatic logic [6:0] glyph_lo(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed an/seg/dp=%03h expected=%03h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      fh    = 3'b000;
      bh    = 2'b00;
      pos   = 0;
      exp_o = 12'hFFF;
   endtask

   // A digit step happens two edges after clk_fast is first seen high following a low sample
   task automatic model_edge();
      logic tk;
      logic dark;
      tk = fh[1] & ~fh[2];
      if (tk) begin
         pos         = (pos + 1) % 4;
         exp_o[11:8] = 4'b1111;
      end else begin
         dark = bus.blank_mask[pos] | (bus.blink_mask[pos] & bh[1]);
         if (dark) exp_o = 12'hFFF;
         else      exp_o = {~(4'b0001 << pos), glyph_lo(bus.digits_bcd[pos*4 +: 4]), ~bus.dp_mask[pos]};
      end
      fh = {fh[1:0], bus.clk_fast};
      bh = {bh[0], bus.clk_blink};
   endtask

   task automatic step(input string tag);
      @(posedge master_clk);
      if (rst) model_edge();
      else     model_reset();
      @(negedge master_clk);
      check(tag, {bus.an, bus.seg, bus.dp}, exp_o);
   endtask

   task automatic run(input int n, input int period, input string tag);
      for (int i = 0; i < n; i++) begin
         if (period > 0) begin
            bus.clk_fast = ((fast_cnt % period) < (period / 2));
            fast_cnt++;
         end
         step(tag);
      end
   endtask

   initial begin
      rst            = 1'b0;
      bus.clk_fast   = 1'b0;
      bus.clk_blink  = 1'b0;
      bus.digits_bcd = 16'h4321;
      bus.dp_mask    = 4'b0000;
      bus.blink_mask = 4'b0000;
      bus.blank_mask = 4'b0000;
      model_reset();

      run(6, 2, "reset_hold");
      rst      = 1'b1;
      fast_cnt = 4;
      run(40, 8, "scan_4321");

      bus.blink_mask = 4'b0001;
      bus.clk_blink  = 1'b1;
      run(40, 8, "blink_on");
      bus.clk_blink  = 1'b0;
      run(40, 8, "blink_off");
      bus.blink_mask = 4'b0000;

      bus.digits_bcd = 16'hFA00;
      bus.dp_mask    = 4'b0100;
      run(40, 8, "dash_dp");
      bus.blank_mask = 4'b0100;
      run(40, 8, "blank_dp");
      bus.blank_mask = 4'b0000;
      bus.dp_mask    = 4'b0000;
      bus.digits_bcd = 16'h4321;

      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         if (pos == 2 && exp_o[11:8] == 4'b1011) found = 1'b1;
         else run(1, 8, "seek_idx2");
      end
      if (!found) begin
         vectors++;
         miscompares++;
         $error("FAIL seek_idx2: observed digit=%0d expected=2", pos);
      end
      #2;
      rst = 1'b0;
      #1;
      check("rst_async", {bus.an, bus.seg, bus.dp}, 12'hFFF);
      model_reset();
      run(3, 2, "rst_mid");
      bus.clk_fast = 1'b0;
      rst          = 1'b1;
      run(4, 0, "release_low");
      bus.clk_fast = 1'b1;
      run(2, 0, "rise_wait");
      run(1, 0, "rise_guard");
      check("guard_an", {bus.an, 8'h00}, {4'b1111, 8'h00});
      run(1, 0, "rise_first");
      check("first_digit1", {bus.an, bus.seg, 1'b0}, {4'b1101, 7'h24, 1'b0});

      run(50, 0, "hold_high");
      check("hold_one_step", {bus.an, bus.seg, 1'b0}, {4'b1101, 7'h24, 1'b0});

      for (int i = 0; i < 300; i++) begin
         bus.clk_fast   = ($urandom_range(0, 3) == 0);
         bus.clk_blink  = ($urandom_range(0, 7) < 3);
         bus.digits_bcd = 16'($urandom);
         bus.dp_mask    = 4'($urandom);
         bus.blink_mask = 4'($urandom);
         bus.blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         run(1, 0, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
